msf_timekeeper: RTL
===================

# msf_timekeeper

Local time-of-day keeper and sync controller for the MSF clock. It takes the per-minute hour/minute result from the time/date decoder and runs a BCD hh:mm:ss counter from the 1 Hz second tick. A sync state machine decides when to load decoded time, when to trust it, and when to fall back to free-running holdover. The display path reads its outputs.

## Interface
Parameters:
- CONFIRM_FRAMES, 2: consecutive consistent decodes required to enter SYNCED (range 1..7).
- HOLDOVER_MIN, 60: local minute wraps allowed in HOLDOVER before dropping to UNSYNC (range 1..255).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- tick_i  in  1  one-cycle pulse per received second.
- dec_valid_i  in  1  one-cycle pulse: decoded fields valid, referring to the minute that starts now.
- dec_hour_h_i  in  2  decoded hour tens (BCD).
- dec_hour_l_i  in  4  decoded hour units.
- dec_minute_h_i  in  3  decoded minute tens.
- dec_minute_l_i  in  4  decoded minute units.
- hour_h_o  out  2, hour_l_o  out  4, minute_h_o  out  3, minute_l_o  out  4, second_h_o  out  3, second_l_o  out  4: local time, BCD.
- state_o  out  2  0 = UNSYNC, 1 = SYNCED, 2 = HOLDOVER (3 unused).
- sync_o  out  1  high when state_o is SYNCED or HOLDOVER.

## Operation
- **Time counter:**
  - Each tick_i increments seconds 00..59.
  - A seconds wrap increments minutes 00..59; a minutes wrap increments hours 00..23, then wraps to 00:00:00.
  - Digit carries are pure BCD.
  - The counter runs in every state, including before the first load.
- **Decode qualification:** dec_valid_i is ignored entirely when any of these holds: hour > 23, minute > 59, or a units digit > 9.
- **Match definition:** a qualified decode matches when its hh:mm equals the current local hh:mm and local seconds = 00, using pre-update values.
- **Load:** every qualified decode that does not match loads hh:mm and sets seconds = 00. A matching decode leaves the counter unchanged.
- **Tick gap counter:**
  - 7 bits, saturating at 127.
  - Increments on tick_i and clears on any qualified decode.
  - A miss event fires on the tick that takes it from 61 to 62.
- **confirm count:** 3 bits.
- **State machine** (UNSYNC after reset):
  - UNSYNC, qualified decode: on match, confirm+1; on mismatch, load and confirm = 1. When confirm reaches CONFIRM_FRAMES, go to SYNCED (CONFIRM_FRAMES = 1 means the first qualified decode syncs).
  - SYNCED, match: stay.
  - SYNCED, mismatch: load, confirm = 1, go to UNSYNC.
  - SYNCED, miss event: go to HOLDOVER and clear the holdover count.
  - HOLDOVER, match: go to SYNCED.
  - HOLDOVER, mismatch: load, confirm = 1, go to UNSYNC.
  - HOLDOVER, local minute wrap: holdover count +1. Reaching HOLDOVER_MIN goes to UNSYNC with confirm = 0.
  - Further miss events in HOLDOVER or UNSYNC change nothing.

## Timing
- All outputs are registered.
- Reset values: all time digits 0, state_o = 0, sync_o = 0. Internal counters are also 0.
- A load or increment is visible on outputs the cycle after the dec_valid_i or tick_i edge.
- A state change is visible one cycle after its cause.
- tick_i and dec_valid_i in the same cycle:
  - The decode wins: matching uses pre-tick values, and the tick does not advance seconds.
  - The gap counter clears.
- A minute wrap and the HOLDOVER_MIN limit landing on the same tick both take effect: the time rolls over and the state goes to UNSYNC on that edge.
- A reset assertion at any cycle forces reset values immediately. The first tick after release starts from 00:00:00.

## Structure
- Package msf_pkg holds:
  - the state encoding constants (UNSYNC, SYNCED, HOLDOVER)
  - BCD field widths shared with the decoder
  - GAP_MISS_TICKS = 62
- Sub-module bcd_time_counter:
  - inputs: tick, load, hh:mm
  - outputs: hh:mm:ss and a minute_wrap pulse
- The sync FSM, qualification, compare, and gap/holdover counters stay in msf_timekeeper.

## Test plan
- Reset, then 3 ticks: output 00:00:03, state 0.
- Decode 12:34 → 12:34:00 and state 0. After 60 ticks, decode 12:35 → state 1, sync_o = 1.
- In SYNCED at 23:59:59, one tick → 00:00:00, state stays 1. Then decode 00:00 → state 1.
- In SYNCED, 62 ticks with no decode → state 2. With HOLDOVER_MIN = 2, the second minute wrap after that → state 0, and time keeps running.
- Decode hour 24, or minute units 0xA → ignored: time, state and gap counter unchanged.
- In SYNCED at 10:20:00, decode 10:25 → 10:25:00 and state 0. Asserting rst_i mid-count → all outputs 0 asynchronously.

Source files
------------

// File: rtl/msf_pkg.sv
// Shared definitions for the MSF time-of-day keeper: sync state encoding,
// BCD field widths used by the decoder interface, and field qualification.
package msf_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC   = 2'd0,
        ST_SYNCED   = 2'd1,
        ST_HOLDOVER = 2'd2
    } sync_state_e;

    localparam int HOUR_H_W = 2;
    localparam int HOUR_L_W = 4;
    localparam int MIN_H_W  = 3;
    localparam int MIN_L_W  = 4;
    localparam int SEC_H_W  = 3;
    localparam int SEC_L_W  = 4;

    localparam int           GAP_W          = 7;
    localparam logic [6:0]   GAP_MISS_TICKS = 7'd62;
    localparam logic [6:0]   GAP_MAX        = 7'd127;

    // True when the decoded hh:mm is a legal BCD time of day.
    function automatic logic fields_valid(
        input logic [HOUR_H_W-1:0] hh,
        input logic [HOUR_L_W-1:0] hl,
        input logic [MIN_H_W-1:0]  mh,
        input logic [MIN_L_W-1:0]  ml
    );
        logic hour_ok;
        hour_ok = (hh < 2'd2) || ((hh == 2'd2) && (hl <= 4'd3));
        return hour_ok && (hl <= 4'd9) && (mh <= 3'd5) && (ml <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss counter advanced by a per-second tick, with a load port for
// decoded hh:mm. Load has priority over tick and zeroes the seconds.
module bcd_time_counter
    import msf_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic                load_i,
    input  logic [HOUR_H_W-1:0] load_hour_h_i,
    input  logic [HOUR_L_W-1:0] load_hour_l_i,
    input  logic [MIN_H_W-1:0]  load_minute_h_i,
    input  logic [MIN_L_W-1:0]  load_minute_l_i,
    output logic [HOUR_H_W-1:0] hour_h_o,
    output logic [HOUR_L_W-1:0] hour_l_o,
    output logic [MIN_H_W-1:0]  minute_h_o,
    output logic [MIN_L_W-1:0]  minute_l_o,
    output logic [SEC_H_W-1:0]  second_h_o,
    output logic [SEC_L_W-1:0]  second_l_o,
    output logic                minute_wrap_o
);

    // Combinational so the sync FSM can act on the same edge the time rolls over.
    assign minute_wrap_o = tick_i && !load_i && (second_h_o == 3'd5) && (second_l_o == 4'd9);

    // Load or ripple-carry increment of the six BCD digits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hour_h_o   <= '0;
            hour_l_o   <= '0;
            minute_h_o <= '0;
            minute_l_o <= '0;
            second_h_o <= '0;
            second_l_o <= '0;
        end else if (load_i) begin
            hour_h_o   <= load_hour_h_i;
            hour_l_o   <= load_hour_l_i;
            minute_h_o <= load_minute_h_i;
            minute_l_o <= load_minute_l_i;
            second_h_o <= '0;
            second_l_o <= '0;
        end else if (tick_i) begin
            if (second_l_o != 4'd9) begin
                second_l_o <= second_l_o + 4'd1;
            end else begin
                second_l_o <= '0;
                if (second_h_o != 3'd5) begin
                    second_h_o <= second_h_o + 3'd1;
                end else begin
                    second_h_o <= '0;
                    if (minute_l_o != 4'd9) begin
                        minute_l_o <= minute_l_o + 4'd1;
                    end else begin
                        minute_l_o <= '0;
                        if (minute_h_o != 3'd5) begin
                            minute_h_o <= minute_h_o + 3'd1;
                        end else begin
                            minute_h_o <= '0;
                            if ((hour_h_o == 2'd2) && (hour_l_o == 4'd3)) begin
                                hour_h_o <= '0;
                                hour_l_o <= '0;
                            end else if (hour_l_o == 4'd9) begin
                                hour_l_o <= '0;
                                hour_h_o <= hour_h_o + 2'd1;
                            end else begin
                                hour_l_o <= hour_l_o + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/msf_timekeeper.sv
// MSF time-of-day keeper: qualifies per-minute decodes, loads or confirms the
// local BCD clock, and tracks sync / holdover status.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_UNSYNC   | not trusted; counting consecutive consistent decodes
//   ST_SYNCED   | local time confirmed by the decoder
//   ST_HOLDOVER | decodes missing; free-running for up to HOLDOVER_MIN min
module msf_timekeeper
    import msf_pkg::*;
#(
    parameter int CONFIRM_FRAMES = 2,
    parameter int HOLDOVER_MIN   = 60
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic                dec_valid_i,
    input  logic [HOUR_H_W-1:0] dec_hour_h_i,
    input  logic [HOUR_L_W-1:0] dec_hour_l_i,
    input  logic [MIN_H_W-1:0]  dec_minute_h_i,
    input  logic [MIN_L_W-1:0]  dec_minute_l_i,
    output logic [HOUR_H_W-1:0] hour_h_o,
    output logic [HOUR_L_W-1:0] hour_l_o,
    output logic [MIN_H_W-1:0]  minute_h_o,
    output logic [MIN_L_W-1:0]  minute_l_o,
    output logic [SEC_H_W-1:0]  second_h_o,
    output logic [SEC_L_W-1:0]  second_l_o,
    output logic [1:0]          state_o,
    output logic                sync_o
);

    localparam logic [2:0] CONFIRM_TGT = 3'(CONFIRM_FRAMES);
    localparam logic [7:0] HOLD_TGT    = 8'(HOLDOVER_MIN);

    sync_state_e      state;
    logic [2:0]       confirm_cnt;
    logic [2:0]       confirm_inc;
    logic [7:0]       hold_cnt;
    logic [7:0]       hold_inc;
    logic [GAP_W-1:0] gap_cnt;
    logic             qual;
    logic             match;
    logic             load;
    logic             tick_adv;
    logic             miss;
    logic             minute_wrap;

    assign qual = dec_valid_i &&
                  fields_valid(dec_hour_h_i, dec_hour_l_i, dec_minute_h_i, dec_minute_l_i);

    assign match = qual &&
                   (dec_hour_h_i == hour_h_o) && (dec_hour_l_i == hour_l_o) &&
                   (dec_minute_h_i == minute_h_o) && (dec_minute_l_i == minute_l_o) &&
                   (second_h_o == 3'd0) && (second_l_o == 4'd0);

    assign load     = qual && !match;
    // A decode in the same cycle as a tick owns the edge; the tick is dropped.
    assign tick_adv = tick_i && !qual;
    assign miss     = tick_adv && (gap_cnt == GAP_MISS_TICKS - 7'd1);

    assign confirm_inc = (confirm_cnt == 3'd7) ? 3'd7 : confirm_cnt + 3'd1;
    assign hold_inc    = hold_cnt + 8'd1;
    assign state_o     = state;

    bcd_time_counter u_time (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .tick_i          (tick_adv),
        .load_i          (load),
        .load_hour_h_i   (dec_hour_h_i),
        .load_hour_l_i   (dec_hour_l_i),
        .load_minute_h_i (dec_minute_h_i),
        .load_minute_l_i (dec_minute_l_i),
        .hour_h_o        (hour_h_o),
        .hour_l_o        (hour_l_o),
        .minute_h_o      (minute_h_o),
        .minute_l_o      (minute_l_o),
        .second_h_o      (second_h_o),
        .second_l_o      (second_l_o),
        .minute_wrap_o   (minute_wrap)
    );

    // Ticks since the last qualified decode, saturating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gap_cnt <= '0;
        end else if (qual) begin
            gap_cnt <= '0;
        end else if (tick_i && (gap_cnt != GAP_MAX)) begin
            gap_cnt <= gap_cnt + 7'd1;
        end
    end

    // Sync state machine with confirm and holdover counters; sync_o registered alongside.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_UNSYNC;
            sync_o      <= 1'b0;
            confirm_cnt <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                ST_UNSYNC: begin
                    if (match) begin
                        confirm_cnt <= confirm_inc;
                        if (confirm_inc >= CONFIRM_TGT) begin
                            state  <= ST_SYNCED;
                            sync_o <= 1'b1;
                        end
                    end else if (load) begin
                        confirm_cnt <= 3'd1;
                        if (CONFIRM_TGT <= 3'd1) begin
                            state  <= ST_SYNCED;
                            sync_o <= 1'b1;
                        end
                    end
                end
                ST_SYNCED: begin
                    if (load) begin
                        confirm_cnt <= 3'd1;
                        state       <= ST_UNSYNC;
                        sync_o      <= 1'b0;
                    end else if (miss) begin
                        hold_cnt <= '0;
                        state    <= ST_HOLDOVER;
                        sync_o   <= 1'b1;
                    end
                end
                ST_HOLDOVER: begin
                    if (match) begin
                        state  <= ST_SYNCED;
                        sync_o <= 1'b1;
                    end else if (load) begin
                        confirm_cnt <= 3'd1;
                        state       <= ST_UNSYNC;
                        sync_o      <= 1'b0;
                    end else if (minute_wrap) begin
                        hold_cnt <= hold_inc;
                        if (hold_inc >= HOLD_TGT) begin
                            confirm_cnt <= '0;
                            state       <= ST_UNSYNC;
                            sync_o      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_UNSYNC;
                    sync_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
